// File: rtl/i2c_pkg.sv
// Shared I2C constants and the target-side FSM state encoding.
// Also imported by the bench that drives the master side of the bus.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one asynchronous bus line, plus rise/fall pulses
// derived from the synchronized level. Flops come out of reset at 1 (bus idle).
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // [0] and [1] form the synchronizer; [2] is the previous synchronized level.
  logic [2:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_sync[2];
  assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address: receives bytes on master writes and serves
// tx_data on master reads. SDA is open-drain and SCL is never stretched.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_req,
  output logic              busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic w_addr_match, w_enter_rd, w_sda_low;

  i2c_state_e r_state, w_state_next;

  logic [2:0]        r_bit_cnt;
  logic              r_byte_full;
  logic [DATA_W-1:0] r_shift;
  logic              r_master_nack;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_tx_req;
  logic              r_busy;

  i2c_sync_edge u_sync_scl (
    .clk     (clk),
    .reset   (reset),
    .i_async (i2c_scl),
    .o_level (w_scl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge u_sync_sda (
    .clk     (clk),
    .reset   (reset),
    .i_async (i2c_sda),
    .o_level (w_sda),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl;
  assign w_stop       = w_sda_rise & w_scl;
  assign w_addr_match = (r_shift[DATA_W-1:1] == SLAVE_ADDR);
  assign w_enter_rd   = (w_state_next == RD_DATA) && (r_state != RD_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_stop) begin
      w_state_next = IDLE;
    end else if (w_start) begin
      w_state_next = ADDR;
    end else begin
      case (r_state)
        ADDR:     if (w_scl_fall && r_byte_full) w_state_next = w_addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (w_scl_fall) w_state_next = r_shift[0] ? RD_DATA : WR_DATA;
        WR_DATA:  if (w_scl_fall && r_byte_full) w_state_next = WR_ACK;
        WR_ACK:   if (w_scl_fall) w_state_next = WR_DATA;
        RD_DATA:  if (w_scl_fall && (r_bit_cnt == 3'd7)) w_state_next = RD_ACK;
        RD_ACK:   if (w_scl_fall) w_state_next = r_master_nack ? IGNORE : RD_DATA;
        default:  w_state_next = r_state;
      endcase
    end
  end

  // While tx_req is high the shift register is still loading, so bit 7 comes
  // straight from tx_data to avoid a one-clk release glitch on SDA.
  always_comb begin
    w_sda_low = 1'b0;
    case (r_state)
      ADDR_ACK, WR_ACK: w_sda_low = 1'b1;
      RD_DATA:          w_sda_low = r_tx_req ? ~tx_data[DATA_W-1] : ~r_shift[DATA_W-1];
      default:          w_sda_low = 1'b0;
    endcase
  end

  assign i2c_sda = w_sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt     <= 3'd0;
      r_byte_full   <= 1'b0;
      r_shift       <= '0;
      r_master_nack <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_req      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_stop) begin
        r_bit_cnt   <= 3'd0;
        r_byte_full <= 1'b0;
        r_busy      <= 1'b0;
      end else if (w_start) begin
        r_bit_cnt   <= 3'd0;
        r_byte_full <= 1'b0;
      end else begin
        case (r_state)
          ADDR, WR_DATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[DATA_W-2:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_full <= 1'b1;
                if (r_state == WR_DATA) begin
                  r_rx_data  <= {r_shift[DATA_W-2:0], w_sda};
                  r_rx_valid <= 1'b1;
                end
              end
            end
          end
          RD_DATA: begin
            if (w_scl_fall && (r_bit_cnt != 3'd7)) begin
              r_shift   <= {r_shift[DATA_W-2:0], 1'b1};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          RD_ACK: begin
            if (w_scl_rise) r_master_nack <= w_sda;
          end
          default: ;
        endcase

        // Every state change starts a fresh byte or acknowledge slot.
        if (w_state_next != r_state) begin
          r_bit_cnt   <= 3'd0;
          r_byte_full <= 1'b0;
        end
        if (w_enter_rd) r_tx_req <= 1'b1;
        if (r_tx_req)   r_shift  <= tx_data;
        if ((r_state == ADDR) && (w_state_next == ADDR_ACK)) r_busy <= 1'b1;
        if ((r_state == ADDR) && (w_state_next == IGNORE))   r_busy <= 1'b0;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL take parameter SLAVE_ADDR, default 7'h50, the 7-bit address this target responds to.
REQ-002 The block SHALL use reset reset, asynchronous, active-high; clock clk.
REQ-003 Port clk  input  1  system clock, at least 8x the SCL rate.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port i2c_scl  input  1  bus clock from the master.
REQ-006 Port i2c_sda  inout  1  bus data, open-drain: the block drives 0 or 'z, never 1.
REQ-007 Port tx_data  input  8  byte to send on master read, sampled when tx_req=1.
REQ-008 Port rx_data  output  8  last byte received on master write.
REQ-009 Port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-010 Port tx_req  output  1  one-clk pulse when tx_data is sampled.
REQ-011 Port busy  output  1  high from an addressed START until STOP.

Function
REQ-012 SCL and SDA SHALL pass through 2-flop synchronizers; rise and fall edges are detected on the synchronized values.
REQ-013 START SHALL be a synchronized SDA fall while SCL=1; from any state, including mid-byte (repeated START), go to ADDR and clear the bit counter.
REQ-014 STOP SHALL be a synchronized SDA rise while SCL=1; from any state, go to IDLE, release SDA and clear busy.
REQ-015 FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-016 ADDR SHALL shift SDA MSB-first on 8 SCL rising edges: 7 address bits, then RW (1=read).
REQ-017 On the 8th SCL fall in ADDR, an address match SHALL go to ADDR_ACK, drive SDA=0 and set busy; a mismatch SHALL go to IGNORE with SDA released.
REQ-018 The ACK low SHALL be held from the 8th SCL fall until the 9th SCL fall.
REQ-019 At the 9th SCL fall in ADDR_ACK, RW=0 SHALL go to WR_DATA and release SDA; RW=1 SHALL go to RD_DATA.
REQ-020 WR_DATA SHALL shift 8 bits MSB-first on SCL rises.
REQ-021 At the 8th SCL rise in WR_DATA, rx_data SHALL update and rx_valid SHALL pulse in the same clk.
REQ-022 At the 8th SCL fall in WR_DATA, the FSM SHALL go to WR_ACK and drive SDA=0; at the next SCL fall it SHALL return to WR_DATA.
REQ-023 On each entry to RD_DATA, tx_req SHALL pulse, tx_data SHALL load the shift register, and bit 7 SHALL drive immediately.
REQ-024 In RD_DATA, each later SCL fall SHALL advance one bit; a '1' bit SHALL release SDA and a '0' bit SHALL drive it low.
REQ-025 At the 8th SCL fall in RD_DATA, the FSM SHALL release SDA and go to RD_ACK.
REQ-026 In RD_ACK, SDA SHALL be sampled on the SCL rise: 0 (ACK) SHALL re-enter RD_DATA at the SCL fall; 1 (NACK) SHALL go to IGNORE.
REQ-027 The bit counter SHALL be 3 bits and reset to 0 on START and on entry to each data or address byte.
REQ-028 IGNORE SHALL keep SDA released and leave only on START or STOP.
REQ-029 The slave SHALL NOT stretch SCL.

Reset
REQ-030 Reset SHALL force: state IDLE, SDA released, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, counters 0, synchronizers 1.
REQ-031 Reset mid-transfer SHALL release SDA within the same cycle, with no partial byte reported.

Structure
REQ-032 Package i2c_pkg SHALL hold the state enum and the ADDR_W=7 and DATA_W=8 constants, shared with the master bench.
REQ-033 Sub-module i2c_sync_edge SHALL hold the 2-flop synchronizer plus rise/fall detect, instanced once each for SCL and SDA.
REQ-034 Estimated size is 200-300 lines of RTL.

Verification
REQ-035 Write to 7'h50 with data 8'hA5, then STOP: ACK after address, rx_data=8'hA5, exactly one rx_valid, ACK after data, busy=0 after STOP.
REQ-036 Address 7'h51: no ACK (SDA stays high on the 9th clock), no rx_valid, busy=0 throughout; the next START to 7'h50 is accepted.
REQ-037 Read from 7'h50 with tx_data=8'h3C then 8'hC3, master ACK then NACK: bus bits 00111100 then 11000011, two tx_req pulses, SDA released after NACK.
REQ-038 Repeated START after 4 bits of a write byte: no rx_valid for the partial byte; the new address is decoded correctly.
REQ-039 Reset asserted while the slave drives the ACK low: SDA goes 'z at once and all outputs are at reset values.
REQ-040 Three back-to-back write bytes 8'h00, 8'hFF, 8'h81: three rx_valid pulses with matching rx_data, each byte ACKed.
